// File: rtl/nmr_pio_pkg.sv
// nmr_pio_pkg: register addresses and bus width shared by the NMR PIO ports
package nmr_pio_pkg;
  localparam int BUS_W = 32;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;
endpackage

// File: rtl/nmr_sync_edge.sv
// nmr_sync_edge: per-bit synchronizer chain with rising-edge detection
module nmr_sync_edge #(
  parameter int WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] rise
);
  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      prev_q <= '0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev_q <= chain[SYNC_STAGES-1];
    end
  assign sync_q = chain[SYNC_STAGES-1];
  assign rise = sync_q & ~prev_q;
endmodule

// File: rtl/nmr_status_pio_in.sv
// nmr_status_pio_in: Avalon-MM status input port with edge capture and maskable irq.
// Define NMR_STATUS_PIO_IRQ_EN to build the IRQMASK register and irq logic.
module nmr_status_pio_in
  import nmr_pio_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [BUS_W-1:0] writedata,
  output logic [BUS_W-1:0] readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] sync_q, rise, edgecap, irqmask, clr, rd;
  logic wr;
  nmr_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset(reset), .din(in_port), .sync_q(sync_q), .rise(rise)
  );
  assign wr = chipselect && !write_n;
  assign clr = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  // OR-ing rise after the clear makes a simultaneous set win
  always_ff @(posedge clk or posedge reset)
    if (reset) edgecap <= '0;
    else edgecap <= (edgecap & ~clr) | rise;
`ifdef NMR_STATUS_PIO_IRQ_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) irqmask <= '0;
    else if (wr && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
`else
  assign irqmask = '0;
`endif
  assign irq = |(edgecap & irqmask);
  always_comb
    rd = address == ADDR_DATA    ? sync_q  :
         address == ADDR_IRQMASK ? irqmask :
         address == ADDR_EDGECAP ? edgecap : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) readdata <= '0;
    else readdata <= BUS_W'(rd);
endmodule

// File: tb/tb_nmr_status_pio_in.sv
// tb_nmr_status_pio_in: randomized and directed checks against a history-based model
module tb_nmr_status_pio_in;
  localparam int S = 2;
  logic clk = 0, reset = 1, chipselect = 0, write_n = 1, irq;
  logic [1:0] address = 0;
  logic [31:0] writedata = 0, readdata, in_port = 0;
  int checks = 0, errors = 0;
  logic [31:0] hist[$];
  logic [31:0] m_cap, m_mask, exp_rd;

  nmr_status_pio_in #(.WIDTH(32), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic exp_irq();
`ifdef NMR_STATUS_PIO_IRQ_EN
    return |(m_cap & m_mask);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back(32'h0);
    m_cap = 0;
    m_mask = 0;
    exp_rd = 0;
  endtask

  task automatic chk(string tag);
    checks++;
    assert (readdata === exp_rd) else begin
      errors++;
      $error("FAIL %s readdata got %h want %h", tag, readdata, exp_rd);
    end
    checks++;
    assert (irq === exp_irq()) else begin
      errors++;
      $error("FAIL %s irq got %b want %b", tag, irq, exp_irq());
    end
  endtask

  // hist[0] is the newest sample; the synchronized value lags S samples behind
  task automatic cyc(string tag);
    logic [31:0] sy, rise, clr;
    logic wr;
    sy = hist[S-1];
    rise = hist[S-1] & ~hist[S];
    wr = chipselect && !write_n;
    clr = (wr && address == 2'd3) ? writedata : 32'h0;
    exp_rd = address == 2'd0 ? sy : address == 2'd2 ? m_mask : address == 2'd3 ? m_cap : 32'h0;
    @(posedge clk);
    hist.push_front(in_port);
    void'(hist.pop_back());
    m_cap = (m_cap & ~clr) | rise;
`ifdef NMR_STATUS_PIO_IRQ_EN
    if (wr && address == 2'd2) m_mask = writedata;
`endif
    #1;
    chk(tag);
  endtask

  task automatic bus_wr(logic [1:0] a, logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    cyc("write");
    chipselect = 0; write_n = 1; writedata = $urandom;
  endtask

  task automatic rd_at(logic [1:0] a, string tag);
    address = a;
    cyc(tag);
    cyc(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    for (int a = 0; a < 4; a++) rd_at(2'(a), "reset_read");
    in_port = 32'hA5;
    address = 0;
    for (int i = 0; i < 5; i++) cyc("sync_latency");
    rd_at(3, "cap_a5");
    bus_wr(3, 32'hFFFF_FFFF);
    in_port = 0;
    repeat (4) cyc("settle");
    bus_wr(3, 32'hFFFF_FFFF);
    bus_wr(2, 32'h1);
    rd_at(2, "mask_rd");
    in_port = 32'h1; cyc("pulse0"); cyc("pulse0");
    in_port = 0;
    address = 3;
    repeat (4) cyc("cap_bit0");
    in_port = 32'h2; cyc("pulse1"); cyc("pulse1");
    in_port = 0;
    repeat (4) cyc("cap_bit1");
    bus_wr(3, 32'h1);
    rd_at(3, "w1c_bit0");
    bus_wr(3, 32'h0);
    rd_at(3, "w1c_zero");
    in_port = 32'h1; cyc("collide"); cyc("collide");
    bus_wr(3, 32'h1);
    in_port = 0;
    rd_at(3, "collide_rd");
    bus_wr(2, 32'hFFFF_FFFF);
    in_port = 32'h00F0; repeat (4) cyc("toggle");
    in_port = 32'h0F00; repeat (4) cyc("toggle");
    rd_at(2, "mask_all");
    rd_at(3, "cap_toggle");
    #2 reset = 1;
    #1;
    model_reset();
    chk("mid_reset");
    @(posedge clk);
    #1 reset = 0;
    in_port = 0;
    for (int a = 0; a < 4; a++) rd_at(2'(a), "post_reset");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) in_port = in_port ^ (32'h1 << $urandom_range(31)) ^ ($urandom_range(7) == 0 ? $urandom : 32'h0);
      address = 2'($urandom_range(3));
      chipselect = $urandom_range(3) == 0;
      write_n = !(chipselect && $urandom_range(1) == 1);
      writedata = $urandom_range(1) ? $urandom : (32'h1 << $urandom_range(31));
      cyc("random");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
